// File: rtl/fifo_burst_ctrl.sv
// Push-button driven burst controller for a bank of NUM_CH FIFOs.
// Optional stall abort is enabled by defining FIFO_CTRL_TIMEOUT_EN.
module fifo_burst_ctrl #(
   parameter int  NUM_CH      = 4,
   parameter int  BURST_W     = 4,
   parameter int  SYNC_STAGES = 2,
   parameter int  TIMEOUT     = 255,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               button,
   input  logic               wren,
   input  logic [CH_W-1:0]    ch_sel,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [NUM_CH-1:0]  full,
   input  logic [NUM_CH-1:0]  empty,
   output logic [NUM_CH-1:0]  wen,
   output logic [NUM_CH-1:0]  ren,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int REM_W = BURST_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    btn_prev_q;
   logic                    req;
   logic [NUM_CH-1:0]       ch_q;
   logic [REM_W-1:0]        remaining_q;
   logic [NUM_CH-1:0]       sel_oh;
   logic                    ch_valid;
   logic                    reject;
   logic                    accept;
   logic                    in_burst;
   logic                    gate_ok;
   logic                    strobing;
   logic                    abort;
   logic [REM_W-1:0]        len_init;

   // Button synchroniser and rising-edge detector
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q     <= '0;
         btn_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], button};
         btn_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign req = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

   // Out-of-range ch_sel decodes to all-zero, which doubles as the range check
   always_comb begin
      sel_oh = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch_sel == CH_W'(i)) sel_oh[i] = 1'b1;
      end
   end

   assign ch_valid = |sel_oh;
   assign reject   = !ch_valid || (wren ? |(sel_oh & full) : |(sel_oh & empty));
   assign accept   = (state_q == S_IDLE) && req && !reject;
   assign len_init = (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, burst_len};

   assign in_burst = (state_q == S_WRITE) || (state_q == S_READ);
   assign gate_ok  = (state_q == S_WRITE) ? ~|(ch_q & full) : ~|(ch_q & empty);
   assign strobing = in_burst && gate_ok && !abort;

`ifdef FIFO_CTRL_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [STALL_W-1:0] stall_q;

   // Abort fires in the cycle after the count reaches TIMEOUT, so no strobe leaks out
   assign abort = in_burst && (stall_q == STALL_W'(TIMEOUT));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (!in_burst || strobing) begin
         stall_q <= '0;
      end else if (!abort) begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end
`else
   assign abort = 1'b0;
`endif

   // Latched request and burst counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ch_q        <= '0;
         remaining_q <= '0;
      end else if (accept) begin
         ch_q        <= sel_oh;
         remaining_q <= len_init;
      end else if (strobing && (remaining_q > REM_W'(1))) begin
         remaining_q <= remaining_q - REM_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = wren ? S_WRITE : S_READ;
            else        state_d = S_IDLE;
         end
         S_WRITE, S_READ: begin
            if (abort)                                     state_d = S_IDLE;
            else if (strobing && remaining_q == REM_W'(1)) state_d = S_DONE;
            else                                           state_d = state_q;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wen  = '0;
      ren  = '0;
      busy = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      case (state_q)
         S_IDLE: err = req && reject;
         S_WRITE: begin
            busy = 1'b1;
            err  = abort;
            if (strobing) wen = ch_q;
         end
         S_READ: begin
            busy = 1'b1;
            err  = abort;
            if (strobing) ren = ch_q;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule
